timer_counter: RTL and testbench
================================

Name: timer_counter

Overview:
- Memory-mapped countdown timer peripheral, attached to the data-bus bridge in the MEM stage.
- Its irq output drives one bit of the CP0 hardware-interrupt vector, HARDWARE_INTERRUPT[5:0].
- Two instances are planned, on HARDWARE_INTERRUPT[0] and [1].
- Software programs PRESET and CTRL; the block counts down once per clk and raises an interrupt at zero.

Parameters:
- PRESET_RST, 32'd0, reset value of the PRESET register.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high. Clock is clk.
- addr  in  2  word offset within device: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
- we  in  1  bus write strobe, already decoded for this device by the bridge
- wd  in  32  write data
- rd  out  32  combinational read data for the current addr
- irq  out  1  interrupt request to CP0: irq = irq_flag & CTRL.IM

Behaviour:
- Registers:
  - CTRL[0] EN: enable.
  - CTRL[2:1] MODE: 0 = one-shot, 1 = auto-reload, 2/3 behave as 0.
  - CTRL[3] IM: interrupt mask.
  - CTRL[31:4] read 0, writes ignored.
  - PRESET: 32-bit, read/write.
  - COUNT: 32-bit, read-only; writes ignored.
  - addr 3 reads 0; writes ignored.
- Reset: CTRL=0, PRESET=PRESET_RST, COUNT=0, state=IDLE, irq_flag=0, so irq=0.
- All bus writes take effect at the clk edge where we=1.
- rd is combinational: reading COUNT in the same cycle as an update returns the pre-edge value.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN, go to LOAD; else stay. COUNT holds.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: go to IDLE; COUNT holds (pause).
  - CNT, COUNT>1: COUNT <= COUNT-1.
  - CNT, COUNT<=1: COUNT <= 0; irq_flag <= 1; go to INT.
  - INT, MODE 0: EN <= 0; go to IDLE. irq_flag stays set.
  - INT, MODE 1: irq_flag <= 0 (one-cycle pulse); go to IDLE. EN is still 1, so the counter reloads automatically.
- Latency:
  - irq rises PRESET+2 edges after the CTRL-write edge (PRESET>=1).
  - PRESET=0 behaves as PRESET=1.
  - Mode-1 period is PRESET+3 cycles between irq pulses.
- irq_flag clear: any CTRL write clears irq_flag. This is the software acknowledge for mode 0.
- Simultaneous events:
  - A bus CTRL write wins over the FSM's EN clear in INT in the same cycle.
  - A PRESET write during CNT affects only the next LOAD.
  - A CTRL write with EN=0 during CNT pauses at the next edge; re-enabling enters LOAD, so it does not resume.
- rst mid-count: everything returns to reset values at that edge and irq drops immediately.
- No arithmetic wrap: COUNT never decrements below 0.

Decomposition:
- Shared parameters include holds:
  - device offsets (CTRL/PRESET/COUNT)
  - CTRL bit indices (EN, MODE, IM)
  - MODE encodings
  - FSM state encodings
- Single flat module, no sub-module.
- The bridge instantiates timer_counter twice and ORs nothing; each irq goes to its own CP0 interrupt bit.

Test Plan:
- Reset then read all offsets -> CTRL=0, PRESET=0, COUNT=0, irq=0.
- Write PRESET=3, then CTRL=4'b1001 (IM=1, mode 0, EN=1) -> COUNT reads 3, 2, 1, 0 on consecutive cycles; irq high 5 edges after the CTRL write; CTRL.EN reads 0 afterwards; irq stays high.
- From that state, write CTRL=4'b1000 -> irq low next cycle; COUNT stays 0; no restart.
- PRESET=2, CTRL=4'b1011 (mode 1) -> irq one-cycle pulses every 5 cycles, repeated at least 3 times; COUNT reloads to 2.
- PRESET=10, mode 0, IM=0 -> irq never asserts. Then write CTRL with EN=0 at COUNT=5 -> COUNT holds at 5. Re-enable -> LOAD, so COUNT returns to 10.
- Assert rst while COUNT=4 in mode 0 -> next edge: COUNT=0, CTRL=0, irq=0, FSM idle. Writes to COUNT and addr 3 -> no effect.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the countdown timer peripheral:
// register offsets, CTRL bit positions, mode encodings and FSM states.
package timer_counter_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_e;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer; raises irq when COUNT reaches zero.
// Bus writes land at the clk edge; rd is combinational from current state.
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter logic [31:0] PRESET_RST = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       preset_q, preset_d;
  logic [31:0]       count_q, count_d;
  logic              irq_flag_q, irq_flag_d;
  state_e            state_q, state_d;

  logic       en;
  logic       im;
  logic [1:0] mode;
  logic       ctrl_wr;
  logic       preset_wr;

  logic load_cnt, dec_cnt, expire, fsm_clr_en, fsm_clr_flag;

  assign en        = ctrl_q[CTRL_EN];
  assign im        = ctrl_q[CTRL_IM];
  assign mode      = ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO];
  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign preset_wr = we && (addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_CNT;
      ST_CNT: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (count_q <= 32'd1) begin
          state_d = ST_INT;
        end
      end
      ST_INT:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_cnt     = 1'b0;
    dec_cnt      = 1'b0;
    expire       = 1'b0;
    fsm_clr_en   = 1'b0;
    fsm_clr_flag = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_LOAD: load_cnt = 1'b1;
      ST_CNT: begin
        if (en) begin
          if (count_q > 32'd1) begin
            dec_cnt = 1'b1;
          end else begin
            expire = 1'b1;
          end
        end
      end
      ST_INT: begin
        // Modes 2/3 fall back to one-shot behaviour.
        if (mode == MODE_RELOAD) begin
          fsm_clr_flag = 1'b1;
        end else begin
          fsm_clr_en = 1'b1;
        end
      end
    endcase
  end

  // A bus CTRL write takes priority over the FSM's EN clear and flag updates.
  always_comb begin
    ctrl_d = ctrl_q;
    if (fsm_clr_en) ctrl_d[CTRL_EN] = 1'b0;
    if (ctrl_wr)    ctrl_d = wd[CTRL_W-1:0];

    preset_d = preset_q;
    if (preset_wr) preset_d = wd;

    count_d = count_q;
    if (load_cnt)     count_d = preset_q;
    else if (dec_cnt) count_d = count_q - 32'd1;
    else if (expire)  count_d = 32'd0;

    irq_flag_d = irq_flag_q;
    if (expire)       irq_flag_d = 1'b1;
    if (fsm_clr_flag) irq_flag_d = 1'b0;
    if (ctrl_wr)      irq_flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      preset_q   <= PRESET_RST;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    rd = 32'd0;
    unique case (addr)
      ADDR_CTRL:   rd = {{(32-CTRL_W){1'b0}}, ctrl_q};
      ADDR_PRESET: rd = preset_q;
      ADDR_COUNT:  rd = count_q;
      default:     rd = 32'd0;
    endcase
  end

  assign irq = irq_flag_q & im;

endmodule

// File: tb/tb_timer_counter.sv
// Directed bench for timer_counter: stimulus pushes expectations to a queue,
// a monitor pops and compares them against rd/irq on each observation strobe.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  addr = 2'd0;
  logic        we = 1'b0;
  logic [31:0] wd = 32'd0;
  logic [31:0] rd;
  logic        irq;
  logic        obs_vld = 1'b0;

  int n_applied = 0;
  int n_miscmp  = 0;

  typedef struct {
    bit          is_irq;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sbq[$];

  timer_counter #(.PRESET_RST(32'd0)) dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .wd   (wd),
    .rd   (rd),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  always @(posedge obs_vld) begin
    exp_t e;
    logic [31:0] act;
    if (sbq.size() == 0) begin
      n_miscmp++;
      $display("FAIL unexpected_observation: queue empty at %0t", $time);
    end else begin
      e = sbq.pop_front();
      act = e.is_irq ? {31'd0, irq} : rd;
      n_applied++;
      if (act !== e.val) begin
        n_miscmp++;
        $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr = a;
    wd   = d;
    we   = 1'b1;
    tick();
    we   = 1'b0;
  endtask

  task automatic observe(input exp_t e);
    sbq.push_back(e);
    obs_vld = 1'b1;
    #1;
    obs_vld = 1'b0;
    #1;
  endtask

  task automatic exp_rd(input logic [1:0] a, input logic [31:0] v, input string name);
    exp_t e;
    addr     = a;
    e.is_irq = 1'b0;
    e.val    = v;
    e.name   = name;
    observe(e);
  endtask

  task automatic exp_irq(input logic v, input string name);
    exp_t e;
    e.is_irq = 1'b1;
    e.val    = {31'd0, v};
    e.name   = name;
    observe(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sbq.size());
    $fatal(1, "timeout");
  end

  initial begin
    int cnt_tab[16];
    cnt_tab = '{0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0, 0, 2, 1, 0, 0};

    // Reset and read every offset
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_rd(2'd0, 32'd0, "rst_ctrl");
    exp_rd(2'd1, 32'd0, "rst_preset");
    exp_rd(2'd2, 32'd0, "rst_count");
    exp_rd(2'd3, 32'd0, "rst_addr3");
    tick();
    exp_irq(1'b0, "rst_irq");

    // One-shot, PRESET=3, IM=1: irq high PRESET+2 edges after CTRL write
    wr(2'd1, 32'd3);
    exp_rd(2'd1, 32'd3, "preset_rb");
    wr(2'd0, 32'h9);
    exp_rd(2'd2, 32'd0, "os_count_e0");
    tick();
    exp_rd(2'd2, 32'd0, "os_count_load");
    tick();
    exp_rd(2'd2, 32'd3, "os_count_3");
    exp_irq(1'b0, "os_irq_e2");
    tick();
    exp_rd(2'd2, 32'd2, "os_count_2");
    tick();
    exp_rd(2'd2, 32'd1, "os_count_1");
    exp_irq(1'b0, "os_irq_e4");
    tick();
    exp_rd(2'd2, 32'd0, "os_count_0");
    exp_irq(1'b1, "os_irq_e5");
    exp_rd(2'd0, 32'h9, "os_ctrl_in_int");
    tick();
    exp_rd(2'd0, 32'h8, "os_en_cleared");
    exp_irq(1'b1, "os_irq_held");
    tick();
    exp_irq(1'b1, "os_irq_held2");
    exp_rd(2'd2, 32'd0, "os_count_stays0");

    // Acknowledge by CTRL write: irq drops, no restart
    wr(2'd0, 32'h8);
    exp_irq(1'b0, "ack_irq");
    exp_rd(2'd0, 32'h8, "ack_ctrl");
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_irq(1'b0, "ack_irq_stays");
      exp_rd(2'd2, 32'd0, "ack_no_restart");
    end

    // Auto-reload, PRESET=2: pulses every 5 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int n = 1; n <= 15; n++) begin
      tick();
      exp_irq((n == 4) || (n == 9) || (n == 14), "ar_irq");
      exp_rd(2'd2, cnt_tab[n], "ar_count");
    end
    wr(2'd0, 32'h0);
    tick();
    tick();

    // One-shot, IM=0, pause and re-enable
    wr(2'd1, 32'd10);
    exp_rd(2'd1, 32'd10, "p10_preset");
    wr(2'd0, 32'h1);
    tick();
    for (int n = 2; n <= 6; n++) begin
      tick();
      exp_rd(2'd2, 32'(12 - n), "p10_count");
      exp_irq(1'b0, "p10_irq_masked");
    end
    wr(2'd0, 32'h0);
    exp_rd(2'd2, 32'd5, "pause_count_e7");
    tick();
    exp_rd(2'd2, 32'd5, "pause_count_e8");
    tick();
    exp_rd(2'd2, 32'd5, "pause_count_e9");
    wr(2'd0, 32'h1);
    exp_rd(2'd2, 32'd5, "reen_count_g0");
    tick();
    exp_rd(2'd2, 32'd5, "reen_count_load");
    tick();
    exp_rd(2'd2, 32'd10, "reen_reloaded");
    for (int n = 3; n <= 8; n++) begin
      tick();
      exp_rd(2'd2, 32'(12 - n), "reen_count");
    end

    // Reset mid-count at COUNT=4
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_rd(2'd2, 32'd0, "mid_rst_count");
    exp_rd(2'd0, 32'd0, "mid_rst_ctrl");
    exp_rd(2'd1, 32'd0, "mid_rst_preset");
    exp_irq(1'b0, "mid_rst_irq");
    tick();
    exp_rd(2'd2, 32'd0, "idle_after_rst");
    wr(2'd2, 32'd123);
    exp_rd(2'd2, 32'd0, "count_ro");
    wr(2'd3, 32'd55);
    exp_rd(2'd3, 32'd0, "addr3_ro");
    exp_rd(2'd1, 32'd0, "addr3_no_side");
    wr(2'd0, 32'hFFFF_FFF0);
    exp_rd(2'd0, 32'd0, "ctrl_upper_ignored");

    // CTRL write in INT beats the one-shot EN clear
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    tick();
    tick();
    exp_rd(2'd2, 32'd1, "race_count_1");
    tick();
    exp_irq(1'b1, "race_irq_set");
    wr(2'd0, 32'h9);
    exp_rd(2'd0, 32'h9, "race_ctrl_wins");
    exp_irq(1'b0, "race_irq_acked");
    tick();
    tick();
    exp_rd(2'd2, 32'd1, "race_restart");
    tick();
    exp_irq(1'b1, "race_irq_again");

    tick();
    if (sbq.size() != 0) begin
      n_miscmp++;
      $display("FAIL scoreboard_drain: %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscmp);
    $finish;
  end

endmodule
